// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared sequencer/interrupt constants and FSM encoding
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  // Vector table placement shared with the sequencer and assembler scripts
  localparam int unsigned DEF_VEC_BASE  = 32'h0000_0010;
  localparam int          DEF_VEC_SHIFT = 2;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder
module int_prio_enc #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = i[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ps_int_ctrl.sv
// rtl/ps_int_ctrl.sv - program sequencer interrupt controller
// Edge-latched pending bits, software mask, fixed priority, req/ack/rti handshake.
module ps_int_ctrl
  import core_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter int          PMA_SIZE  = 16,
  parameter int unsigned VEC_BASE  = DEF_VEC_BASE,
  parameter int          VEC_SHIFT = DEF_VEC_SHIFT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                imask_wen,
  input  logic [NUM_IRQ-1:0]  imask_wdata,
  input  logic                ps_int_en,
  input  logic                ps_idle,
  input  logic                ps_int_ack,
  input  logic                ps_rti,
  output logic                int_req,
  output logic [PMA_SIZE-1:0] int_vec,
  output logic [2:0]          int_id,
  output logic                int_active,
  output logic [NUM_IRQ-1:0]  int_pend,
  output logic [NUM_IRQ-1:0]  imask
);

  int_state_e         state;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr;
  logic               win_valid;
  logic [2:0]         win_idx;
  logic [PMA_SIZE-1:0] win_vec;

  assign rise     = irq_in & ~irq_d;
  assign eligible = int_pend & ~imask;
  assign clr      = (state == ST_REQ && ps_int_ack) ? (NUM_IRQ'(1) << int_id) : '0;
  assign win_vec  = PMA_SIZE'(VEC_BASE + (32'(win_idx) << VEC_SHIFT));

  int_prio_enc #(.N(NUM_IRQ), .W(3)) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // A rise on the ack edge wins over the clear, so no edge is lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d    <= '0;
      int_pend <= '0;
      imask    <= '0;
    end else begin
      irq_d    <= irq_in;
      int_pend <= (int_pend & ~clr) | rise;
      if (imask_wen) imask <= imask_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      int_id     <= '0;
      int_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid && (ps_int_en || ps_idle)) begin
            state   <= ST_REQ;
            int_req <= 1'b1;
            int_id  <= win_idx;
            int_vec <= win_vec;
          end
        end
        // Committed request: nothing but ack moves it
        ST_REQ: begin
          if (ps_int_ack) begin
            state      <= ST_SERVICE;
            int_req    <= 1'b0;
            int_active <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (ps_rti) begin
            state      <= ST_IDLE;
            int_active <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          int_req    <= 1'b0;
          int_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps_int_ctrl.sv
// tb/tb_ps_int_ctrl.sv - scoreboard bench for ps_int_ctrl
module tb_ps_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        imask_wen;
  logic [3:0]  imask_wdata;
  logic        ps_int_en, ps_idle, ps_int_ack, ps_rti;
  logic        int_req;
  logic [15:0] int_vec;
  logic [2:0]  int_id;
  logic        int_active;
  logic [3:0]  int_pend, imask;

  always #5 clk = ~clk;

  ps_int_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .imask_wen(imask_wen),
    .imask_wdata(imask_wdata), .ps_int_en(ps_int_en), .ps_idle(ps_idle),
    .ps_int_ack(ps_int_ack), .ps_rti(ps_rti), .int_req(int_req),
    .int_vec(int_vec), .int_id(int_id), .int_active(int_active),
    .int_pend(int_pend), .imask(imask)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [15:0] vec;
  } exp_t;
  exp_t sb[$];

  // reference: mode 0 waiting, 1 requesting, 2 in service
  logic [3:0] m_pend, m_mask, m_prev;
  int         m_mode, m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_mode = 0; m_id = 0;
  endtask

  task automatic model_edge();
    logic [3:0] rise, elig, clr;
    int w;
    if (!reset) begin
      model_reset();
      return;
    end
    rise   = irq_in & ~m_prev;
    m_prev = irq_in;
    elig   = m_pend & ~m_mask;
    clr    = 4'b0;
    if (m_mode == 0) begin
      if (elig != 0 && (ps_int_en || ps_idle)) begin
        w = -1;
        for (int i = 0; i < 4; i++) if (w < 0 && elig[i]) w = i;
        m_id   = w;
        m_mode = 1;
        sb.push_back('{m_id, 16'(32'h10 + m_id * 4)});
      end
    end else if (m_mode == 1) begin
      if (ps_int_ack) begin
        clr[m_id] = 1'b1;
        m_mode    = 2;
      end
    end else if (ps_rti) begin
      m_mode = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (imask_wen) m_mask = imask_wdata;
  endtask

  task automatic step(input logic [3:0] irq, input logic en, input logic idle,
                      input logic ack, input logic rti, input logic wen,
                      input logic [3:0] wd);
    irq_in = irq; ps_int_en = en; ps_idle = idle; ps_int_ack = ack;
    ps_rti = rti; imask_wen = wen; imask_wdata = wd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  logic seen = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (!reset) begin
      seen = 1'b0;
    end else begin
      check("pend", 32'(int_pend), 32'(m_pend));
      check("imask", 32'(imask), 32'(m_mask));
      check("active", 32'(int_active), 32'(m_mode == 2));
      check("req", 32'(int_req), 32'(m_mode == 1));
      if (int_req && !seen) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got id %0d expected no request", int_id);
        end else begin
          cur = sb.pop_front();
          check("req_id", 32'(int_id), 32'(cur.id));
          check("req_vec", 32'(int_vec), 32'(cur.vec));
        end
      end else if (int_req) begin
        check("hold_id", 32'(int_id), 32'(cur.id));
        check("hold_vec", 32'(int_vec), 32'(cur.vec));
      end
      seen = int_req;
    end
  end

  initial begin
    logic [3:0] irq;
    reset = 1'b0; irq_in = 0; imask_wen = 0; imask_wdata = 0;
    ps_int_en = 0; ps_idle = 0; ps_int_ack = 0; ps_rti = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 32'(int_req), 0);
    check("rst_vec", 32'(int_vec), 0);
    check("rst_id", 32'(int_id), 0);
    check("rst_active", 32'(int_active), 0);
    check("rst_pend", 32'(int_pend), 0);
    check("rst_imask", 32'(imask), 0);
    reset = 1'b1;

    // single source
    step(4'b0100, 1, 0, 0, 0, 0, 0);
    check("t1_pend", 32'(int_pend), 32'h4);
    step(4'b0000, 1, 0, 0, 0, 0, 0);
    check("t1_req", 32'(int_req), 1);
    check("t1_id", 32'(int_id), 2);
    check("t1_vec", 32'(int_vec), 32'h18);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t1_hold", 32'(int_req), 1);
    step(0, 1, 0, 1, 0, 0, 0);
    check("t1_active", 32'(int_active), 1);
    check("t1_clr", 32'(int_pend), 0);
    step(0, 1, 0, 0, 1, 0, 0);

    // two sources on the same edge
    step(4'b1010, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t2_id_a", 32'(int_id), 1);
    check("t2_vec_a", 32'(int_vec), 32'h14);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t2_id_b", 32'(int_id), 3);
    check("t2_vec_b", 32'(int_vec), 32'h1c);
    step(0, 1, 0, 1, 0, 0, 0);
    check("t2_pend0", 32'(int_pend), 0);
    step(0, 1, 0, 0, 1, 0, 0);

    // masked source
    step(0, 1, 0, 0, 0, 1, 4'b0001);
    step(4'b0001, 1, 0, 0, 0, 0, 0);
    step(4'b0001, 1, 0, 0, 0, 0, 0);
    step(4'b0001, 1, 0, 0, 0, 0, 0);
    check("t3_masked_req", 32'(int_req), 0);
    check("t3_masked_pend", 32'(int_pend), 1);
    step(0, 1, 0, 0, 0, 1, 4'b0000);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t3_unmask_req", 32'(int_req), 1);
    check("t3_unmask_vec", 32'(int_vec), 32'h10);

    // no nesting in service
    step(0, 1, 0, 1, 0, 0, 0);
    step(4'b0001, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t4_nonest", 32'(int_req), 0);
    step(0, 1, 0, 0, 1, 0, 0);
    check("t4_rti_edge", 32'(int_req), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("t4_after_rti", 32'(int_req), 1);
    check("t4_id", 32'(int_id), 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    check("t4_rti_idle", 32'(int_active), 0);

    // idle wake and disabled
    step(4'b0010, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("t5_wake", 32'(int_req), 1);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(4'b0100, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t5_disabled", 32'(int_req), 0);

    // asynchronous reset during request
    step(0, 1, 0, 0, 0, 1, 4'b1000);
    check("t6_req", 32'(int_req), 1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("t6_async_req", 32'(int_req), 0);
    check("t6_async_active", 32'(int_active), 0);
    check("t6_async_pend", 32'(int_pend), 0);
    check("t6_async_imask", 32'(imask), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      irq = irq_in;
      if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
      step(irq,
           $urandom_range(0, 7) != 0,
           1'($urandom),
           (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0,
           4'($urandom));
    end
    #1;
    check("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
